// File: rtl/vip_pkg.sv
// Shared types and constants for the grayscale pattern generator:
// FSM states, pattern selects and the noise LFSR definition.
package vip_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    localparam logic [1:0] PAT_HRAMP   = 2'd0;
    localparam logic [1:0] PAT_VRAMP   = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_NOISE   = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/vip_lfsr16.sv
// 16-bit Fibonacci LFSR driving the impulse-noise pattern; reloads the seed
// at every frame start so each frame carries the same noise sequence.
module vip_lfsr16
    import vip_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        reload,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst || reload) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/vip_gray_pattern_gen.sv
// Synthetic grayscale video source producing the pe_frame_* pre-image stream
// with programmable frame timing and selectable test patterns.
//
//  state  | meaning
//  IDLE   | stopped, all outputs 0, waiting for enable
//  VSYNC  | V_SYNC lines with vsync high
//  VBACK  | V_BACK blank lines after sync
//  ACTIVE | V_ACT lines, first H_ACT ticks of each line carry pixels
//  VFRONT | V_FRONT blank lines, then restart (enable) or stop
module vip_gray_pattern_gen
    import vip_pkg::*;
#(
    parameter int H_ACT   = 640,
    parameter int H_BLANK = 160,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 20,
    parameter int V_ACT   = 480,
    parameter int V_FRONT = 10,
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       pe_frame_vsync,
    output logic       pe_frame_href,
    output logic       pe_frame_clken,
    output logic [7:0] pe_img_Y,
    output logic       frame_done
);

    localparam int H_TOT  = H_ACT + H_BLANK;
    localparam int V_MAX1 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
    localparam int V_MAX2 = (V_ACT > V_FRONT) ? V_ACT : V_FRONT;
    localparam int V_MAX  = (V_MAX1 > V_MAX2) ? V_MAX1 : V_MAX2;
    localparam int HW     = $clog2(H_TOT + 1);
    localparam int VW     = $clog2(V_MAX + 1);
    localparam int DW     = $clog2(CLK_DIV + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT_W  = HW'(H_ACT);
    localparam logic [DW-1:0] D_LAST   = DW'(CLK_DIV - 1);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_SYNC - 1);
    localparam logic [VW-1:0] VB_LAST  = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_LAST  = VW'(V_ACT - 1);
    localparam logic [VW-1:0] VF_LAST  = VW'(V_FRONT - 1);

    state_t          state, state_nxt;
    logic [DW-1:0]   div_cnt, div_nxt;
    logic [HW-1:0]   h_cnt, h_nxt;
    logic [VW-1:0]   v_cnt, v_nxt;
    logic [VW-1:0]   v_last;
    logic [1:0]      pat_q;
    logic            tick, line_end, v_at_last;
    logic            href, clken, frame_end, vsync_entry;
    logic [7:0]      x8, y8, pix;
    logic [15:0]     lfsr;
    logic            lfsr_unused;

    assign tick      = (div_cnt == D_LAST);
    assign line_end  = (h_cnt == H_LAST);
    assign v_at_last = (v_cnt == v_last);
    assign href      = (state == ST_ACTIVE) && (h_cnt < H_ACT_W);
    assign clken     = tick && href;
    assign frame_end = (state == ST_VFRONT) && tick && line_end && v_at_last;

    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:  v_last = VS_LAST;
            ST_VBACK:  v_last = VB_LAST;
            ST_ACTIVE: v_last = VA_LAST;
            ST_VFRONT: v_last = VF_LAST;
            default:   v_last = '0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        div_nxt     = div_cnt;
        h_nxt       = h_cnt;
        v_nxt       = v_cnt;
        vsync_entry = 1'b0;
        if (state == ST_IDLE) begin
            div_nxt = '0;
            h_nxt   = '0;
            v_nxt   = '0;
            if (enable) begin
                state_nxt   = ST_VSYNC;
                vsync_entry = 1'b1;
            end
        end else begin
            div_nxt = tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                h_nxt = line_end ? '0 : h_cnt + 1'b1;
                if (line_end) begin
                    v_nxt = v_cnt + 1'b1;
                    if (v_at_last) begin
                        v_nxt = '0;
                        case (state)
                            ST_VSYNC:  state_nxt = ST_VBACK;
                            ST_VBACK:  state_nxt = ST_ACTIVE;
                            ST_ACTIVE: state_nxt = ST_VFRONT;
                            ST_VFRONT: begin
                                // enable is only looked at here, so a drop never truncates a frame
                                state_nxt   = enable ? ST_VSYNC : ST_IDLE;
                                vsync_entry = enable;
                            end
                            default:   state_nxt = ST_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            pat_q   <= PAT_HRAMP;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            if (vsync_entry) begin
                pat_q <= pattern_sel;
            end
        end
    end

    vip_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .enable (clken),
        .reload (vsync_entry),
        .state  (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:8];
    assign x8 = 8'(h_cnt);
    assign y8 = 8'(v_cnt);

    always_comb begin
        pix = x8;
        case (pat_q)
            PAT_HRAMP:   pix = x8;
            PAT_VRAMP:   pix = y8;
            PAT_CHECKER: pix = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            PAT_NOISE: begin
                if (lfsr[7:0] == 8'h00) begin
                    pix = 8'hFF;
                end else if (lfsr[7:0] == 8'h01) begin
                    pix = 8'h00;
                end else begin
                    pix = x8;
                end
            end
            default:     pix = x8;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pe_frame_vsync <= 1'b0;
            pe_frame_href  <= 1'b0;
            pe_frame_clken <= 1'b0;
            pe_img_Y       <= 8'd0;
            frame_done     <= 1'b0;
        end else begin
            pe_frame_vsync <= (state == ST_VSYNC);
            pe_frame_href  <= href;
            pe_frame_clken <= clken;
            pe_img_Y       <= href ? pix : 8'd0;
            frame_done     <= frame_end;
        end
    end

endmodule

// File: tb/tb_vip_gray_pattern_gen.sv
// Directed bench for vip_gray_pattern_gen: four instances with different
// geometries, each output compared every clk against a frame-position model.
module tb_vip_gray_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en   [4];
    logic [1:0] psel [4];
    logic       vs   [4];
    logic       hr   [4];
    logic       ck   [4];
    logic       fd   [4];
    logic [7:0] yy   [4];

    int total = 0;
    int bad   = 0;
    int cur_u = 0;
    int cnt_ck, cnt_hr, imp_obs, imp_exp;

    always #5 clk = ~clk;

    vip_gray_pattern_gen #(.H_ACT(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(4),
                           .V_FRONT(1), .CLK_DIV(1)) u_a (
        .clk(clk), .rst(rst), .enable(en[0]), .pattern_sel(psel[0]),
        .pe_frame_vsync(vs[0]), .pe_frame_href(hr[0]), .pe_frame_clken(ck[0]),
        .pe_img_Y(yy[0]), .frame_done(fd[0]));

    vip_gray_pattern_gen #(.H_ACT(16), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(16),
                           .V_FRONT(1), .CLK_DIV(1)) u_b (
        .clk(clk), .rst(rst), .enable(en[1]), .pattern_sel(psel[1]),
        .pe_frame_vsync(vs[1]), .pe_frame_href(hr[1]), .pe_frame_clken(ck[1]),
        .pe_img_Y(yy[1]), .frame_done(fd[1]));

    vip_gray_pattern_gen #(.H_ACT(8), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(4),
                           .V_FRONT(1), .CLK_DIV(3)) u_c (
        .clk(clk), .rst(rst), .enable(en[2]), .pattern_sel(psel[2]),
        .pe_frame_vsync(vs[2]), .pe_frame_href(hr[2]), .pe_frame_clken(ck[2]),
        .pe_img_Y(yy[2]), .frame_done(fd[2]));

    vip_gray_pattern_gen #(.H_ACT(64), .H_BLANK(4), .V_SYNC(1), .V_BACK(1), .V_ACT(64),
                           .V_FRONT(1), .CLK_DIV(1)) u_d (
        .clk(clk), .rst(rst), .enable(en[3]), .pattern_sel(psel[3]),
        .pe_frame_vsync(vs[3]), .pe_frame_href(hr[3]), .pe_frame_clken(ck[3]),
        .pe_img_Y(yy[3]), .frame_done(fd[3]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL u%0d %s idx=%0d obs=%0d exp=%0d", cur_u, tag, idx, obs, exp);
        end
    endtask

    task automatic chk_zero(input int u, input string tag);
        cur_u = u;
        chk({tag, "_vs"}, 0, 32'(vs[u]), 0);
        chk({tag, "_hr"}, 0, 32'(hr[u]), 0);
        chk({tag, "_ck"}, 0, 32'(ck[u]), 0);
        chk({tag, "_y"},  0, 32'(yy[u]), 0);
        chk({tag, "_fd"}, 0, 32'(fd[u]), 0);
    endtask

    // t=0 is the first clk with vsync high; V_SYNC=V_BACK=V_FRONT=1 for all units.
    task automatic run_chk(input int u, input int hact, input int hblk, input int vact,
                           input int cdiv, input int nt, input int sel_a, input int sel_b,
                           input int sw_frame, input int live, input int drop_t,
                           input int psel_t, input int psel_v);
        int lt, fr, f, r, p, ph, ln, h, sel, pix, ex, qi;
        bit live_f, e_vs, e_hr, e_ck, e_fd, fb;
        logic [15:0] lf;
        int q0[$];
        cur_u   = u;
        cnt_ck  = 0;
        cnt_hr  = 0;
        imp_obs = 0;
        imp_exp = 0;
        qi      = 0;
        q0.delete();
        lt = hact + hblk;
        fr = (vact + 3) * lt * cdiv;
        lf = 16'hACE1;
        for (int t = 0; t < nt; t++) begin
            f  = t / fr;
            r  = t % fr;
            p  = r / cdiv;
            ph = r % cdiv;
            ln = p / lt;
            h  = p % lt;
            live_f = (f < live);
            sel    = (f < sw_frame) ? sel_a : sel_b;
            if (r == 0) begin
                lf = 16'hACE1;
                qi = 0;
            end
            e_vs = live_f && (ln == 0);
            e_hr = live_f && (ln >= 2) && (ln < 2 + vact) && (h < hact);
            e_ck = e_hr && (ph == cdiv - 1);
            e_fd = live_f && (r == fr - 1);
            ex   = h % 256;
            pix  = 0;
            if (e_hr) begin
                case (sel)
                    0:       pix = ex;
                    1:       pix = (ln - 2) % 256;
                    2:       pix = (((h / 8) ^ ((ln - 2) / 8)) & 1) != 0 ? 255 : 0;
                    default: pix = (lf[7:0] == 8'h00) ? 255 : (lf[7:0] == 8'h01) ? 0 : ex;
                endcase
            end
            chk("vsync", t, 32'(vs[u]), 32'(e_vs));
            chk("href",  t, 32'(hr[u]), 32'(e_hr));
            chk("clken", t, 32'(ck[u]), 32'(e_ck));
            chk("y",     t, 32'(yy[u]), pix);
            chk("done",  t, 32'(fd[u]), 32'(e_fd));
            if (hr[u] === 1'b1) cnt_hr++;
            if (ck[u] === 1'b1) begin
                cnt_ck++;
                if (sel == 3) begin
                    if (int'(yy[u]) != ex) imp_obs++;
                    if (f == 0) begin
                        q0.push_back(int'(yy[u]));
                    end else if (f == 1 && qi < q0.size()) begin
                        chk("repeat", qi, 32'(yy[u]), q0[qi]);
                        qi++;
                    end
                end
            end
            if (e_ck && sel == 3) begin
                if (pix != ex) imp_exp++;
                fb = lf[0] ^ lf[2] ^ lf[3] ^ lf[5];
                lf = {fb, lf[15:1]};
            end
            if (t == drop_t) en[u] = 1'b0;
            if (t == psel_t) psel[u] = 2'(psel_v);
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 4; u++) begin
            en[u]   = 1'b0;
            psel[u] = 2'd0;
        end
        repeat (3) step();
        for (int u = 0; u < 4; u++) chk_zero(u, "reset");
        rst = 1'b0;
        step();
        step();
        chk_zero(0, "idle");

        // Unit A: sel0 frames, pattern change mid-frame 1, enable dropped in frame 2 active line 2
        en[0] = 1'b1;
        step();
        cur_u = 0;
        chk("vs_latency", 0, 32'(vs[0]), 0);
        step();
        run_chk(0, 8, 4, 4, 1, 84 * 3 + 24, 0, 1, 2, 3, 2 * 84 + 48, 84 + 30, 1);
        chk("a_clken_count", 0, cnt_ck, 96);

        // Unit A: sel3 frame, reset mid-line, restart from vsync
        psel[0] = 2'd3;
        en[0]   = 1'b1;
        step();
        cur_u = 0;
        chk("vs_latency2", 0, 32'(vs[0]), 0);
        step();
        run_chk(0, 8, 4, 4, 1, 31, 3, 3, 99, 99, -1, -1, 0);
        chk("pre_rst_href", 0, 32'(hr[0]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_zero(0, "mid_rst");
        step();
        chk("vs_latency3", 0, 32'(vs[0]), 0);
        step();
        run_chk(0, 8, 4, 4, 1, 168, 3, 3, 99, 99, -1, -1, 0);
        chk("a_impulses", 0, imp_obs, imp_exp);
        chk("a_noise_clken", 0, cnt_ck, 64);
        en[0] = 1'b0;

        // Unit B: 16x16 checkerboard
        en[1]   = 1'b1;
        psel[1] = 2'd2;
        step();
        cur_u = 1;
        chk("vs_latency", 0, 32'(vs[1]), 0);
        step();
        run_chk(1, 16, 4, 16, 1, 380 + 10, 2, 2, 99, 1, 0, -1, 0);
        chk("b_clken_count", 0, cnt_ck, 256);

        // Unit C: CLK_DIV=3 vertical ramp
        en[2]   = 1'b1;
        psel[2] = 2'd1;
        step();
        cur_u = 2;
        chk("vs_latency", 0, 32'(vs[2]), 0);
        step();
        run_chk(2, 8, 4, 4, 3, 252 + 9, 1, 1, 99, 1, 0, -1, 0);
        chk("c_clken_count", 0, cnt_ck, 32);
        chk("c_href_cycles", 0, cnt_hr, 96);

        // Unit D: 64x64 impulse noise over two frames
        en[3]   = 1'b1;
        psel[3] = 2'd3;
        step();
        cur_u = 3;
        chk("vs_latency", 0, 32'(vs[3]), 0);
        step();
        run_chk(3, 64, 4, 64, 1, 2 * 4556 + 5, 3, 3, 99, 2, 4556, -1, 0);
        chk("d_impulses", 0, imp_obs, imp_exp);
        chk("d_clken_count", 0, cnt_ck, 8192);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vip_gray_pattern_gen.md
# vip_gray_pattern_gen

Synthetic grayscale video source that drives the pre-image stream (`pe_frame_vsync` / `pe_frame_href` / `pe_frame_clken` / `pe_img_Y`) consumed by the VIP filter chain. It generates complete frames with programmable active size, blanking and pixel-enable rate, and fills them with selectable test patterns. One pattern is impulse noise, for exercising the median filter without a camera. It sits in place of the camera capture front end, in simulation and on board.

## Interface
- `H_ACT`, 640, active pixels per line
- `H_BLANK`, 160, blank ticks per line (href low)
- `V_SYNC`, 2, lines with vsync high
- `V_BACK`, 20, lines after sync before active
- `V_ACT`, 480, active lines
- `V_FRONT`, 10, lines after active
- `CLK_DIV`, 2, clk cycles per pixel tick (≥1)
- `clk`  in  1  system clock, 50 MHz
- `rst`  in  1  **synchronous, active-high** reset
- `enable`  in  1  run frames while high
- `pattern_sel`  in  2  0 h-ramp, 1 v-ramp, 2 8×8 checkerboard, 3 h-ramp + impulse noise
- `pe_frame_vsync`  out  1  frame sync, active high
- `pe_frame_href`  out  1  line valid
- `pe_frame_clken`  out  1  one-clk pixel strobe
- `pe_img_Y`  out  8  gray pixel
- `frame_done`  out  1  one-clk pulse at end of last V_FRONT line

## Operation
- Tick divider `div_cnt` counts 0..CLK_DIV-1. A tick occurs when `div_cnt`==CLK_DIV-1. All h/v counters advance only on ticks.
- `h_cnt` runs 0..H_ACT+H_BLANK-1. On wrap, `v_cnt` increments within the current state.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT. Each non-IDLE state lasts its line count, then goes to the next state.
  - IDLE→VSYNC on `enable`.
  - VFRONT end→VSYNC if `enable`, else IDLE.
- `enable` falling mid-frame does not truncate: the current frame completes.
- `pattern_sel` is latched on entry to VSYNC. A change mid-frame takes effect next frame.
- vsync = (state==VSYNC).
- href = (state==ACTIVE && h_cnt<H_ACT).
- clken = tick && href.
- Y, with x=h_cnt and y=active line index:
  - sel0: x[7:0]
  - sel1: y[7:0]
  - sel2: (x[3]^y[3]) ? 255 : 0
  - sel3: starts from x[7:0], then overridden by the LFSR.
- LFSR for sel3: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1. It is reloaded on VSYNC entry and advanced on each clken. If lfsr[7:0]==8'h00, Y=255; if 8'h01, Y=0; otherwise the ramp value.
- `pe_img_Y` = 0 whenever href is low.
- Counter widths: ≥ clog2 of the maximum count. Ramps truncate to 8 bits (wrap at 256).

## Timing
- All outputs are registered, one clk after the counter state that produces them.
- Reset: all outputs 0, state IDLE, all counters 0, LFSR = seed.
- First vsync rises 2 clk after the first clk with `enable`=1 in IDLE.
- Frame length = (V_SYNC+V_BACK+V_ACT+V_FRONT)·(H_ACT+H_BLANK)·CLK_DIV clk.
- With CLK_DIV=1, clken is high continuously across the H_ACT pixels. With CLK_DIV=N, clken pulses every N clk while href stays high for the full line.
- `frame_done` coincides with the last tick of VFRONT, including when `enable` is low.
- `rst` asserted mid-frame returns to reset values on the next clk with no partial-line completion.

## Structure
- Package `vip_pkg`: state enum, pattern-select constants, LFSR seed/taps.
- One sub-module `vip_lfsr16` (enable, reload, 16-bit state). The rest is flat.

## Test plan
Unless noted, all scenarios use H_ACT=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACT=4, V_FRONT=1, CLK_DIV=1.
- Frame timing, sel0:
  - Expect 12 clk vsync, then 12 clk blank, then 4 lines each of 8 clken with Y=0..7 followed by 4 idle.
  - `frame_done` every 84 clk.
- sel2, H_ACT=16, V_ACT=16: Y toggles 0/255 every 8 pixels, with phase inverted every 8 lines. Exactly 256 clken per frame.
- CLK_DIV=3, sel1: clken spaced 3 clk apart, href high 24 clk per line, line k Y=k.
- sel3: 4×8=32 pixels. Y matches a reference LFSR model. Impulse count matches the count of lfsr[7:0]∈{0,1}. Sequence is identical in two consecutive frames.
- Control: `enable` dropped in ACTIVE line 2 → frame completes, `frame_done` pulses, then all outputs stay 0. `pattern_sel` changed mid-frame → no effect until the next vsync.
- `rst` pulsed for 1 clk mid-line → next clk all outputs 0. After `enable`, a full frame restarts from vsync.
